// File: rtl/sifive_reset_sequencer.sv
// -----------------------------------------------------------------------------
// sifive_reset_sequencer
//
// Top-of-shell reset generator. It synchronises areset and the per-domain PLL
// lock flags, then debounces them. Once they are clean it releases the domain
// resets in index order, with STAGE_GAP cycles between releases. A lock loss
// or a software request forces the domain resets back on. The reason for the
// most recent reset is held on reset_cause.
//
// Ports:
//   clock         sequencer clock
//   areset        asynchronous active-high reset; deassertion is synchronised
//   locked        per-domain PLL lock flags (asynchronous)
//   sw_reset_req  single-cycle software reset request (synchronous)
//   reset_out     active-high domain resets; bit k is released k-th
//   all_released  high only while every domain is out of reset (RUN)
//   reset_cause   0 = areset, 1 = lock loss, 2 = software
//
// Optional build macro:
//   RESET_SEQ_REVERSE_ASSERT_EN
//     When defined, a software abort from RUN re-asserts the domains in reverse
//     order (DRAIN state), one domain every STAGE_GAP cycles. When undefined,
//     every abort asserts all domains at once.
// -----------------------------------------------------------------------------
module sifive_reset_sequencer #(
    parameter int NUM_DOMAINS   = 4,
    parameter int SYNC_STAGES   = 4,
    parameter int DEBOUNCE_BITS = 8,
    parameter int STAGE_GAP     = 16
) (
    input  logic                   clock,
    input  logic                   areset,
    input  logic [NUM_DOMAINS-1:0] locked,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] reset_out,
    output logic                   all_released,
    output logic [1:0]             reset_cause
);

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(STAGE_GAP - 1);

    localparam logic [1:0] CAUSE_ARESET = 2'd0;
    localparam logic [1:0] CAUSE_LOCK   = 2'd1;
    localparam logic [1:0] CAUSE_SW     = 2'd2;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
        ,
        ST_DRAIN   = 2'd3
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] areset_sync_reg;
    logic                   areset_s;
    logic [NUM_DOMAINS-1:0] locked_s;

    // Async-set chain: areset asserts areset_s at once; deassertion ripples
    // through all SYNC_STAGES flops.
    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            areset_sync_reg <= '1;
        end else begin
            areset_sync_reg <= {areset_sync_reg[SYNC_STAGES-2:0], 1'b0};
        end
    end
    assign areset_s = areset_sync_reg[SYNC_STAGES-1];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_lock_sync
            logic [SYNC_STAGES-1:0] sync_reg;

            always_ff @(posedge clock or posedge areset) begin
                if (areset) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked[gi]};
                end
            end
            assign locked_s[gi] = sync_reg[SYNC_STAGES-1];
        end
    endgenerate

    // The debouncer works from a registered copy of "clean". Aborts react to
    // locked_s directly so that the lock-loss latency stays SYNC_STAGES+1.
    logic clean_reg;
    logic lock_lost;

    assign lock_lost = ~(&locked_s);

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            clean_reg <= 1'b0;
        end else begin
            clean_reg <= ~areset_s & (&locked_s);
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    state_t                   state_reg, state_next;
    logic [DEBOUNCE_BITS-1:0] count_reg, count_next;
    logic [GAP_W-1:0]         gap_reg, gap_next;
    logic [IDX_W-1:0]         idx_reg, idx_next;
    logic [NUM_DOMAINS-1:0]   reset_out_reg, reset_out_next;
    logic                     all_released_reg, all_released_next;
    logic [1:0]               cause_reg, cause_next;
    logic                     hard_abort;
    logic [1:0]               hard_cause;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state_reg        <= ST_HOLD;
            count_reg        <= '1;
            gap_reg          <= '0;
            idx_reg          <= '0;
            reset_out_reg    <= '1;
            all_released_reg <= 1'b0;
            cause_reg        <= CAUSE_ARESET;
        end else begin
            state_reg        <= state_next;
            count_reg        <= count_next;
            gap_reg          <= gap_next;
            idx_reg          <= idx_next;
            reset_out_reg    <= reset_out_next;
            all_released_reg <= all_released_next;
            cause_reg        <= cause_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        count_next        = count_reg;
        gap_next          = gap_reg;
        idx_next          = idx_reg;
        reset_out_next    = reset_out_reg;
        all_released_next = all_released_reg;
        cause_next        = cause_reg;
        hard_abort        = 1'b0;
        hard_cause        = CAUSE_LOCK;

        case (state_reg)
            ST_HOLD: begin
                reset_out_next    = '1;
                all_released_next = 1'b0;
                if (!clean_reg) begin
                    count_next = '1;
                end else if (count_reg != '0) begin
                    count_next = count_reg - DEBOUNCE_BITS'(1);
                end else begin
                    // Domain 0 comes out on the same edge that leaves HOLD.
                    reset_out_next[0] = 1'b0;
                    gap_next          = GAP_RELOAD;
                    idx_next          = IDX_W'(1);
                    if (NUM_DOMAINS == 1) begin
                        state_next        = ST_RUN;
                        all_released_next = 1'b1;
                    end else begin
                        state_next = ST_RELEASE;
                    end
                end
            end

            ST_RELEASE: begin
                if (lock_lost || sw_reset_req) begin
                    hard_abort = 1'b1;
                    hard_cause = lock_lost ? CAUSE_LOCK : CAUSE_SW;
                end else if (gap_reg == '0) begin
                    reset_out_next[idx_reg] = 1'b0;
                    gap_next                = GAP_RELOAD;
                    idx_next                = idx_reg + IDX_W'(1);
                    if (idx_reg == LAST_IDX) begin
                        state_next        = ST_RUN;
                        all_released_next = 1'b1;
                    end
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end

            ST_RUN: begin
                if (lock_lost) begin
                    hard_abort = 1'b1;
                    hard_cause = CAUSE_LOCK;
                end else if (sw_reset_req) begin
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                    if (NUM_DOMAINS > 1) begin
                        // Highest domain goes back into reset first.
                        state_next                  = ST_DRAIN;
                        reset_out_next[NUM_DOMAINS-1] = 1'b1;
                        all_released_next           = 1'b0;
                        cause_next                  = CAUSE_SW;
                        gap_next                    = GAP_RELOAD;
                        idx_next                    = IDX_W'(NUM_DOMAINS - 2);
                    end else begin
                        hard_abort = 1'b1;
                        hard_cause = CAUSE_SW;
                    end
`else
                    hard_abort = 1'b1;
                    hard_cause = CAUSE_SW;
`endif
                end
            end

`ifdef RESET_SEQ_REVERSE_ASSERT_EN
            ST_DRAIN: begin
                // Software requests are ignored while draining.
                if (lock_lost) begin
                    hard_abort = 1'b1;
                    hard_cause = CAUSE_LOCK;
                end else if (gap_reg == '0) begin
                    reset_out_next[idx_reg] = 1'b1;
                    gap_next                = GAP_RELOAD;
                    if (idx_reg == '0) begin
                        state_next = ST_HOLD;
                        count_next = '1;
                    end else begin
                        idx_next = idx_reg - IDX_W'(1);
                    end
                end else begin
                    gap_next = gap_reg - GAP_W'(1);
                end
            end
`endif

            default: begin
                state_next = ST_HOLD;
            end
        endcase

        if (hard_abort) begin
            state_next        = ST_HOLD;
            count_next        = '1;
            reset_out_next    = '1;
            all_released_next = 1'b0;
            cause_next        = hard_cause;
        end
    end

    assign reset_out    = reset_out_reg;
    assign all_released = all_released_reg;
    assign reset_cause  = cause_reg;

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sifive_reset_sequencer
//
// Directed test-plan scenarios followed by a randomised phase. A timing model
// of the sequencer (debounce run length, release/drain edge arithmetic) sits
// in the bench and every clock edge is compared against it.
// -----------------------------------------------------------------------------
module tb_sifive_reset_sequencer;

    localparam int ND   = 4;
    localparam int SS   = 4;
    localparam int DB   = 3;
    localparam int GAP  = 4;
    localparam logic [ND-1:0] FULL = '1;

    localparam int M_HOLD  = 0;
    localparam int M_REL   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic          clock = 1'b0;
    logic          areset = 1'b0;
    logic [ND-1:0] locked = '1;
    logic          sw_reset_req = 1'b0;
    logic [ND-1:0] reset_out;
    logic          all_released;
    logic [1:0]    reset_cause;

    sifive_reset_sequencer #(
        .NUM_DOMAINS  (ND),
        .SYNC_STAGES  (SS),
        .DEBOUNCE_BITS(DB),
        .STAGE_GAP    (GAP)
    ) dut (
        .clock       (clock),
        .areset      (areset),
        .locked      (locked),
        .sw_reset_req(sw_reset_req),
        .reset_out   (reset_out),
        .all_released(all_released),
        .reset_cause (reset_cause)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int            edge_n;
    logic [ND-1:0] hist[$];
    int            m_mode;
    int            m_run;
    int            m_rel_edge;
    int            m_drain_edge;
    logic [1:0]    m_cause;
    logic [ND-1:0] m_out;
    logic          m_all;

    // First edge at which each reset bit / all_released was seen low/high
    int fe[ND];
    int all_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
        end
    endtask

    task automatic clear_marks();
        for (int k = 0; k < ND; k++) fe[k] = -1;
        all_edge = -1;
    endtask

    task automatic model_abort(input logic [1:0] cause);
        m_mode  = M_HOLD;
        m_run   = 0;
        m_cause = cause;
    endtask

    // Advance the model by one clock edge.
    task automatic model_edge(input logic sw);
        int            n;
        logic [ND-1:0] ls;
        logic          cl;
        n  = edge_n;
        // locked_s seen at edge n is the input present SS edges earlier;
        // the debouncer sees it one edge later still.
        ls = (n - SS >= 1) ? hist[n-SS-1] : '0;
        cl = (n >= SS + 2) && (hist[n-SS-2] == FULL);
        case (m_mode)
            M_HOLD: begin
                if (cl) m_run++;
                else m_run = 0;
                if (m_run == (1 << DB)) begin
                    m_rel_edge = n;
                    m_mode     = (ND == 1) ? M_RUN : M_REL;
                end
            end
            M_REL: begin
                if (ls != FULL) model_abort(2'd1);
                else if (sw) model_abort(2'd2);
                else if (n - m_rel_edge >= (ND - 1) * GAP) m_mode = M_RUN;
            end
            M_RUN: begin
                if (ls != FULL) model_abort(2'd1);
                else if (sw) begin
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
                    m_mode       = M_DRAIN;
                    m_drain_edge = n;
                    m_cause      = 2'd2;
`else
                    model_abort(2'd2);
`endif
                end
            end
            default: begin
                if (ls != FULL) model_abort(2'd1);
                else if (n - m_drain_edge >= (ND - 1) * GAP) begin
                    m_mode = M_HOLD;
                    m_run  = 0;
                end
            end
        endcase
        for (int k = 0; k < ND; k++) begin
            case (m_mode)
                M_HOLD:  m_out[k] = 1'b1;
                M_DRAIN: m_out[k] = (n - m_drain_edge) >= (ND - 1 - k) * GAP;
                default: m_out[k] = (n - m_rel_edge) < k * GAP;
            endcase
        end
        m_all = (m_mode == M_RUN);
    endtask

    // One clock edge: drive inputs, take the edge, compare against the model.
    task automatic step(input logic sw, input logic [ND-1:0] lk);
        sw_reset_req = sw;
        locked       = lk;
        @(posedge clock);
        edge_n++;
        hist.push_back(lk);
        model_edge(sw);
        #1;
        sw_reset_req = 1'b0;
        chk("reset_out", 32'(reset_out), 32'(m_out));
        chk("all_released", 32'(all_released), 32'(m_all));
        chk("reset_cause", 32'(reset_cause), 32'(m_cause));
        for (int k = 0; k < ND; k++)
            if (reset_out[k] === 1'b0 && fe[k] < 0) fe[k] = edge_n;
        if (all_released === 1'b1 && all_edge < 0) all_edge = edge_n;
    endtask

    // Assert areset between edges; outputs must react without a clock edge.
    task automatic do_areset(input int cycles);
        areset = 1'b1;
        #1;
        m_mode  = M_HOLD;
        m_run   = 0;
        m_cause = 2'd0;
        m_out   = '1;
        m_all   = 1'b0;
        chk("areset_reset_out", 32'(reset_out), 32'(FULL));
        chk("areset_all_released", 32'(all_released), 32'd0);
        chk("areset_cause", 32'(reset_cause), 32'd0);
        repeat (cycles) @(posedge clock);
        #1;
        areset = 1'b0;
        edge_n = 0;
        hist.delete();
        $display("areset pulse of %0d cycles", cycles);
    endtask

    task automatic run_to_release(input int budget);
        int i;
        i = 0;
        while (all_released !== 1'b1 && i < budget) begin
            step(1'b0, FULL);
            i++;
        end
        chk("release_timeout", 32'(all_released), 32'd1);
    endtask

    initial begin
        int            t;
        int            r;
        int            drop_left;
        logic [ND-1:0] drop_mask;
        logic [ND-1:0] lk;
        logic          sw;

        edge_n = 0;
        clear_marks();
        #2;

        // 1. Power-on release timing
        do_areset(3);
        clear_marks();
        run_to_release(60);
        chk("poweron_bit0_edge", 32'(fe[0]), 32'd13);
        chk("poweron_bit1_edge", 32'(fe[1]), 32'd17);
        chk("poweron_bit2_edge", 32'(fe[2]), 32'd21);
        chk("poweron_bit3_edge", 32'(fe[3]), 32'd25);
        chk("poweron_all_edge", 32'(all_edge), 32'd25);
        chk("poweron_cause", 32'(reset_cause), 32'd0);
        $display("power-on release: bit0 at edge %0d, all at edge %0d", fe[0], all_edge);

        // 2. Lock loss in RUN, then restore
        repeat (3) step(1'b0, FULL);
        t = edge_n;
        repeat (4) step(1'b0, 4'b1011);
        chk("lockloss_still_run", 32'(reset_out), 32'd0);
        step(1'b0, 4'b1011);
        chk("lockloss_edge_t5", 32'(edge_n - t), 32'd5);
        chk("lockloss_reset_out", 32'(reset_out), 32'hF);
        chk("lockloss_cause", 32'(reset_cause), 32'd1);
        r = edge_n;
        clear_marks();
        run_to_release(60);
        chk("relock_bit0_edge", 32'(fe[0] - r), 32'd13);
        chk("relock_bit3_edge", 32'(fe[3] - r), 32'd25);
        $display("lock loss handled, re-release after %0d edges", fe[0] - r);

        // 3. Software reset in RUN
        repeat (2) step(1'b0, FULL);
`ifdef RESET_SEQ_REVERSE_ASSERT_EN
        step(1'b1, FULL);
        chk("drain_step1", 32'(reset_out), 32'h8);
        chk("drain_all_released", 32'(all_released), 32'd0);
        repeat (GAP) step(1'b0, FULL);
        chk("drain_step2", 32'(reset_out), 32'hC);
        repeat (GAP) step(1'b1, FULL);
        chk("drain_step3", 32'(reset_out), 32'hE);
        repeat (GAP) step(1'b0, FULL);
        chk("drain_step4", 32'(reset_out), 32'hF);
`else
        step(1'b1, FULL);
        chk("swreset_reset_out", 32'(reset_out), 32'hF);
        chk("swreset_all_released", 32'(all_released), 32'd0);
`endif
        chk("swreset_cause", 32'(reset_cause), 32'd2);
        r = edge_n;
        clear_marks();
        run_to_release(60);
        chk("swreset_rerelease", 32'(fe[0] - r), 32'd8);
        $display("software reset handled, re-release after %0d edges", fe[0] - r);

        // 4. Simultaneous sw request and lock loss in RELEASE
        do_areset(3);
        clear_marks();
        t = 0;
        while (fe[1] < 0 && t < 40) begin
            step(1'b0, FULL);
            t++;
        end
        chk("release_bit1_seen", 32'(fe[1]), 32'd17);
        repeat (4) step(1'b0, 4'b1110);
        step(1'b1, 4'b1110);
        chk("simul_reset_out", 32'(reset_out), 32'hF);
        chk("simul_cause", 32'(reset_cause), 32'd1);
        run_to_release(60);
        $display("simultaneous abort handled, cause=%0d", m_cause);

        // 5/6. Glitch in HOLD plus ignored sw request in HOLD
        do_areset(3);
        clear_marks();
        repeat (2) step(1'b0, FULL);
        repeat (2) step(1'b0, 4'b1110);
        repeat (6) step(1'b0, FULL);
        step(1'b1, FULL);
        run_to_release(60);
        chk("glitch_bit0_edge", 32'(fe[0]), 32'd17);
        chk("hold_sw_cause", 32'(reset_cause), 32'd0);
        $display("glitch restart: bit0 at edge %0d", fe[0]);

        // areset pulse in the middle of RELEASE
        do_areset(3);
        clear_marks();
        t = 0;
        while (fe[1] < 0 && t < 40) begin
            step(1'b0, FULL);
            t++;
        end
        chk("mid_release_state", 32'(reset_out), 32'hC);
        do_areset(2);
        run_to_release(60);

        // Randomised phase
        drop_left = 0;
        drop_mask = '0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) do_areset(int'($urandom_range(1, 3)));
            lk = FULL;
            if (drop_left > 0) begin
                lk = FULL & ~drop_mask;
                drop_left--;
            end else if ($urandom_range(0, 49) == 0) begin
                drop_mask = ND'(1 << $urandom_range(0, ND - 1));
                drop_left = int'($urandom_range(1, 8));
            end
            sw = ($urandom_range(0, 39) == 0);
            step(sw, lk);
        end
        $display("random phase complete");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
